// File: rtl/dac_adc_pkg.sv
// Shared definitions for the DAC/ADC UART data path (sender and receiver sides).
// Latency: none (types, constants and a pure helper only).
// Backpressure: not applicable.
package dac_adc_pkg;

  localparam int SAMPLE_W = 12;
  localparam int CNT_W    = 13;

  // Samples travel over the UART as two bytes, low byte first.
  localparam bit LOW_BYTE_FIRST = 1'b1;

  // Encodings match the FIFO-to-UART sender so both sides decode alike.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RECV = 2'b01,
    ST_PLAY = 2'b11
  } state_e;

  // Build a 12-bit sample from the two bytes in arrival order.
  // Only the low nibble of the high byte carries sample bits.
  function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [7:0] first_b,
                                                      input logic [7:0] second_b);
    if (LOW_BYTE_FIRST) return {second_b[3:0], first_b};
    else                return {first_b[3:0], second_b};
  endfunction

endpackage

// File: rtl/uart_byte_pairer.sv
// Pairs received UART bytes into 12-bit samples and drops a stale low byte after a quiet period.
// Latency: word_vld/word_dat one cycle after the high-byte strobe; pair_accept and tmo_pulse are combinational.
// Backpressure: none; bytes are taken whenever en is high, a byte coinciding with timeout expiry wins.
module uart_byte_pairer
  import dac_adc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                flush,
  input  logic                byte_vld,
  input  logic [7:0]          byte_dat,
  output logic                pair_accept,
  output logic                word_vld,
  output logic [SAMPLE_W-1:0] word_dat,
  output logic                tmo_pulse
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic                phase_q, phase_d;
  logic [7:0]          low_q, low_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                word_vld_q, word_vld_d;
  logic [SAMPLE_W-1:0] word_q, word_d;

  // Byte phase tracking, low-byte hold, word assembly and idle timeout in phase 1.
  always_comb begin
    phase_d     = phase_q;
    low_d       = low_q;
    tmo_d       = tmo_q;
    word_vld_d  = 1'b0;
    word_d      = word_q;
    pair_accept = 1'b0;
    tmo_pulse   = 1'b0;
    if (flush) begin
      phase_d = 1'b0;
      tmo_d   = '0;
    end else if (en && byte_vld) begin
      tmo_d = '0;
      if (!phase_q) begin
        low_d   = byte_dat;
        phase_d = 1'b1;
      end else begin
        word_d      = pack_sample(low_q, byte_dat);
        word_vld_d  = 1'b1;
        phase_d     = 1'b0;
        pair_accept = 1'b1;
      end
    end else if (en && phase_q) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo_pulse = 1'b1;
        phase_d   = 1'b0;
        low_d     = '0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Pairer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q    <= 1'b0;
      low_q      <= '0;
      tmo_q      <= '0;
      word_vld_q <= 1'b0;
      word_q     <= '0;
    end else begin
      phase_q    <= phase_d;
      low_q      <= low_d;
      tmo_q      <= tmo_d;
      word_vld_q <= word_vld_d;
      word_q     <= word_d;
    end
  end

  assign word_vld = word_vld_q;
  assign word_dat = word_q;

endmodule

// File: rtl/ctrl_uart2fifo.sv
// Receives UART byte pairs, writes 12-bit samples to the DAC FIFO frame by frame and sequences playback.
// Latency: FIFO write one cycle after the high byte; dac_playing_start one cycle after the frame-ending write.
// Backpressure: none upstream; writes while fifo_full are dropped and flagged, bytes during playback are dropped and flagged.
module ctrl_uart2fifo
  import dac_adc_pkg::*;
#(
  parameter int FRAME_LEN   = 1024,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_all,
  input  logic                uart_rx_done,
  input  logic [7:0]          uart_rx_data,
  output logic                fifo_wrreq,
  output logic [SAMPLE_W-1:0] fifo_data,
  input  logic                fifo_full,
  input  logic                fifo_almost_full,
  output logic                dac_playing_start,
  input  logic                dac_playing_done,
  output logic [CNT_W-1:0]    frame_cnt_words,
  output logic                overflow_err,
  output logic                sync_err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_q, start_d;
  logic                ovf_q, ovf_d;
  logic                sync_q, sync_d;

  logic                rx_en;
  logic                flush;
  logic                frame_end;
  logic                pair_accept;
  logic                word_vld;
  logic [SAMPLE_W-1:0] word_dat;
  logic                tmo_pulse;

  uart_byte_pairer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_pairer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (rx_en),
    .flush       (flush),
    .byte_vld    (uart_rx_done),
    .byte_dat    (uart_rx_data),
    .pair_accept (pair_accept),
    .word_vld    (word_vld),
    .word_dat    (word_dat),
    .tmo_pulse   (tmo_pulse)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: arm on start, play when a frame is complete, resume when the DAC drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_all)        state_d = ST_RECV;
      ST_RECV: if (frame_end)        state_d = ST_PLAY;
      ST_PLAY: if (dac_playing_done) state_d = ST_RECV;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and handshake decode; the count already includes the word being written.
  always_comb begin
    rx_en      = (state_q == ST_RECV);
    flush      = (state_q == ST_PLAY) && dac_playing_done;
    fifo_wrreq = word_vld && !fifo_full;
    fifo_data  = word_dat;
    frame_end  = (state_q == ST_RECV) && word_vld &&
                 ((cnt_q == CNT_W'(FRAME_LEN)) || fifo_almost_full);
  end

  // Word counter, playback-start pulse and sticky error flags.
  always_comb begin
    cnt_d = cnt_q;
    if (flush)            cnt_d = '0;
    else if (pair_accept) cnt_d = cnt_q + 1'b1;
    start_d = frame_end;
    ovf_d   = ovf_q | ((state_q == ST_PLAY) && uart_rx_done) | (word_vld && fifo_full);
    sync_d  = sync_q | tmo_pulse;
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      start_q <= 1'b0;
      ovf_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= start_d;
      ovf_q   <= ovf_d;
      sync_q  <= sync_d;
    end
  end

  assign frame_cnt_words   = cnt_q;
  assign dac_playing_start = start_q;
  assign overflow_err      = ovf_q;
  assign sync_err          = sync_q;

endmodule
